button_press_fsm: RTL and testbench

Counter-based debounce and event generator that consumes the 3-flop-synchronized push-button level and produces a clean debounced level plus single-cycle press, release and long-press pulses. It sits directly downstream of the button synchronizer chain and feeds LED/control logic on the Cyclone 10 LP board. Its input is already synchronous to `clk`, so this block adds no synchronization flops.

---
 rtl/button_press_fsm_pkg.sv | 9 +
 rtl/button_press_fsm_if.sv | 10 +
 rtl/button_press_fsm_dbnc_counter.sv | 16 +
 rtl/button_press_fsm.sv | 74 +++++++
 tb/tb_button_press_fsm.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/button_press_fsm_pkg.sv
// btn_pkg: shared FSM states, default timing constants and counter width helper
package btn_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
    localparam int BTN_STABLE_DEF = 500000;
    localparam int BTN_LONG_DEF = 50000000;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/button_press_fsm_if.sv
// button_press_fsm_if: synchronized button level in, debounced level and event strobes out
interface button_press_fsm_if;
    logic btn_sync;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    modport master (output btn_sync, input btn_level, press_pulse, release_pulse, long_pulse);
    modport slave (input btn_sync, output btn_level, press_pulse, release_pulse, long_pulse);
endinterface

// File: rtl/button_press_fsm_dbnc_counter.sv
// dbnc_counter: saturating up-counter with sync clear and terminal-count flag at N-1
module dbnc_counter import btn_pkg::*; #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = cnt_w(N);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc_o = cnt_q == W'(N - 1);
    always_comb cnt_d = clr_i ? '0 : (en_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/button_press_fsm.sv
// button_press_fsm: counter debounce with registered press/release/long-press strobes
// Long-press logic exists only when BTN_LONG_PRESS_EN is defined; otherwise long_pulse is 0.
module button_press_fsm import btn_pkg::*; #(
    parameter int STABLE_CYCLES = BTN_STABLE_DEF,
    parameter int LONG_CYCLES = BTN_LONG_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic clk,
    input logic rst_n,
    button_press_fsm_if.slave bus
);
    btn_state_t state_q, state_d;
    logic pressed, stab_tc;
    logic level_d, press_d, release_d, long_d;
    logic level_q, press_q, release_q, long_q;
    assign pressed = bus.btn_sync ^ ACTIVE_LOW;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = pressed ? PRESS_WAIT : IDLE;
            PRESS_WAIT:   state_d = !pressed ? IDLE : stab_tc ? PRESSED : PRESS_WAIT;
            PRESSED:      state_d = pressed ? PRESSED : RELEASE_WAIT;
            RELEASE_WAIT: state_d = pressed ? PRESSED : stab_tc ? IDLE : RELEASE_WAIT;
            default:      state_d = IDLE;
        endcase
        press_d = state_q == PRESS_WAIT && state_d == PRESSED;
        release_d = state_q == RELEASE_WAIT && state_d == IDLE;
        level_d = state_d == PRESSED || state_d == RELEASE_WAIT;
    end
    // the stability window restarts on every state change, so it never wraps
    dbnc_counter #(.N(STABLE_CYCLES)) u_stab (
        .clk, .rst_n,
        .clr_i(state_d != state_q),
        .en_i(state_q == PRESS_WAIT || state_q == RELEASE_WAIT),
        .tc_o(stab_tc)
    );
`ifdef BTN_LONG_PRESS_EN
    logic hold_tc, long_sent_q, long_sent_d;
    dbnc_counter #(.N(LONG_CYCLES)) u_hold (
        .clk, .rst_n,
        .clr_i(press_d),
        .en_i(state_q == PRESSED && pressed),
        .tc_o(hold_tc)
    );
    always_comb begin
        long_d = state_q == PRESSED && pressed && hold_tc && !long_sent_q;
        long_sent_d = (state_d == IDLE) ? 1'b0 : long_sent_q | long_d;
    end
    always_ff @(posedge clk) long_sent_q <= !rst_n ? 1'b0 : long_sent_d;
`else
    logic unused_long;
    assign unused_long = ^LONG_CYCLES;
    assign long_d = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= 1'b0;
            press_q <= 1'b0;
            release_q <= 1'b0;
            long_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            press_q <= press_d;
            release_q <= release_d;
            long_q <= long_d;
        end
    end
    assign bus.btn_level = level_q;
    assign bus.press_pulse = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse = long_q;
endmodule

// File: tb/tb_button_press_fsm.sv
// tb_button_press_fsm: directed checks of debounce latency, bounce restart, long press and reset
module tb_button_press_fsm;
    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad = 0;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    button_press_fsm_if bus();

    button_press_fsm #(.STABLE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // outputs packed as {level, press, release, long}
    task automatic test_reset();
        logic [3:0] obs;
        rst_n = 1'b0;
        bus.btn_sync = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold k=%0d got=%b want=0000", k, obs);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL reset_idle k=%0d got=%b want=0000", k, obs);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] obs, exp;
        bus.btn_sync = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            exp = {k >= 5, k == 5, 1'b0, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL clean_press k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_clean_release();
        logic [3:0] obs, exp;
        bus.btn_sync = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            exp = {k < 5, 1'b0, k == 5, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL clean_release k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] obs, exp;
        for (int k = 1; k <= 10; k++) begin
            bus.btn_sync = (k == 3);
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            exp = {k >= 8, k == 8, 1'b0, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL bounce_press k=%0d got=%b want=%b", k, obs, exp);
            end
        end
        for (int k = 1; k <= 9; k++) begin
            bus.btn_sync = (k != 2);
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            exp = {k < 7, 1'b0, k == 7, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL bounce_release k=%0d got=%b want=%b", k, obs, exp);
            end
        end
    endtask

    task automatic test_release_glitch();
        logic [3:0] obs, exp;
        bus.btn_sync = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            exp = {k >= 5, k == 5, 1'b0, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL glitch_press k=%0d got=%b want=%b", k, obs, exp);
            end
        end
        for (int k = 1; k <= 6; k++) begin
            bus.btn_sync = (k <= 2);
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            total++;
            if (obs !== 4'b1000) begin
                bad++;
                $display("FAIL glitch_hold k=%0d got=%b want=1000", k, obs);
            end
        end
        test_clean_release();
    endtask

    task automatic test_long_press(input int hold);
        logic [3:0] obs, exp;
        bus.btn_sync = 1'b0;
        for (int k = 1; k <= hold; k++) begin
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            exp = {k >= 5, k == 5, 1'b0, LONG_EN && k == 15};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL long_press hold=%0d k=%0d got=%b want=%b", hold, k, obs, exp);
            end
        end
        test_clean_release();
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, exp;
        bus.btn_sync = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL mid_wait k=%0d got=%b want=0000", k, obs);
            end
        end
        rst_n = 1'b0;
        tick();
        obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_in_flight got=%b want=0000", obs);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            obs = {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
            exp = {k >= 5, k == 5, 1'b0, 1'b0};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL held_through_reset k=%0d got=%b want=%b", k, obs, exp);
            end
        end
        test_clean_release();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_clean_release();
        test_bounce();
        test_release_glitch();
        test_long_press(45);
        test_long_press(20);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
